// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RISC-V core: load-use bubble,
// taken-branch flush, data-memory freeze, memory-timeout flag and perf counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs1,
  input  logic             if_id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_memaccess,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [15:0]      TIMEOUT_V = 16'(MEM_TIMEOUT);
  localparam logic [15:0]      WAIT_MAX  = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  state_e           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             freeze_c, load_use_c, branch_flush_c;

  // Hazard detection and prioritised control outputs
  always_comb begin
    freeze_c   = !dmem_ready && ((state_q == MEM_WAIT) || ex_mem_memaccess);
    load_use_c = id_ex_memread && (id_ex_rd != 5'd0) &&
                 ((if_id_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                  (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    pipe_freeze    = 1'b0;
    branch_flush_c = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze_c) begin
      // branch and load-use re-present once memory completes
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      branch_flush_c = 1'b1;
    end else if (load_use_c) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Next-state for FSM, wait counter, timeout flag and perf counters
  always_comb begin
    state_d = freeze_c ? MEM_WAIT : RUN;
    if (!freeze_c) begin
      wait_cnt_d = 16'd0;
    end else if (state_q == RUN) begin
      wait_cnt_d = 16'd1;
    end else if (wait_cnt_q == WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
    mem_timeout_d = mem_timeout_q || (wait_cnt_d == TIMEOUT_V);
    if ((pipe_freeze || id_ex_bubble) && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (branch_flush_c && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl: two instances (default and
// small parameters) driven in lockstep and compared against an abstract model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic        u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, ma = 1'b0, rdy = 1'b0;

  logic        pcw_a, ifw_a, bub_a, iff_a, exf_a, frz_a, to_a;
  logic [31:0] st_a, fl_a;
  logic        pcw_b, ifw_b, bub_b, iff_b, exf_b, frz_b, to_b;
  logic [2:0]  st_b, fl_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // abstract model state: unbounded counts, saturation applied on compare
  bit      m_wait = 1'b0;
  longint  m_wcnt = 0;
  bit      m_to_a = 1'b0, m_to_b = 1'b0;
  longint  m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .id_ex_rd(rd),
    .id_ex_memread(mr), .ex_branch_taken(br), .ex_mem_memaccess(ma),
    .dmem_ready(rdy), .pc_write(pcw_a), .if_id_write(ifw_a),
    .id_ex_bubble(bub_a), .if_id_flush(iff_a), .id_ex_flush(exf_a),
    .pipe_freeze(frz_a), .mem_timeout(to_a), .stall_cycles(st_a),
    .flush_count(fl_a)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .id_ex_rd(rd),
    .id_ex_memread(mr), .ex_branch_taken(br), .ex_mem_memaccess(ma),
    .dmem_ready(rdy), .pc_write(pcw_b), .if_id_write(ifw_b),
    .id_ex_bubble(bub_b), .if_id_flush(iff_b), .id_ex_flush(exf_b),
    .pipe_freeze(frz_b), .mem_timeout(to_b), .stall_cycles(st_b),
    .flush_count(fl_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // one clock cycle: apply inputs, check at negedge, advance model, pass edge
  task automatic cyc(input bit r, input bit [4:0] s1, input bit [4:0] s2,
                     input bit a1, input bit a2, input bit [4:0] d,
                     input bit m, input bit b, input bit acc, input bit ready);
    bit lu, fz;
    logic [5:0] exp_ctrl;
    rst = r; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; rd = d;
    mr = m; br = b; ma = acc; rdy = ready;
    lu = m && (d != 5'd0) && ((a1 && d == s1) || (a2 && d == s2));
    fz = !ready && (m_wait || acc);
    if (r)       exp_ctrl = 6'b110110;
    else if (fz) exp_ctrl = 6'b000001;
    else if (b)  exp_ctrl = 6'b110110;
    else if (lu) exp_ctrl = 6'b001000;
    else         exp_ctrl = 6'b110000;
    @(negedge clk);
    check("ctrl_a", {58'd0, pcw_a, ifw_a, bub_a, iff_a, exf_a, frz_a}, {58'd0, exp_ctrl});
    check("ctrl_b", {58'd0, pcw_b, ifw_b, bub_b, iff_b, exf_b, frz_b}, {58'd0, exp_ctrl});
    check("stall_a", {32'd0, st_a}, 64'(sat(m_stall, 64'hFFFF_FFFF)));
    check("flush_a", {32'd0, fl_a}, 64'(sat(m_flush, 64'hFFFF_FFFF)));
    check("stall_b", {61'd0, st_b}, 64'(sat(m_stall, 64'd7)));
    check("flush_b", {61'd0, fl_b}, 64'(sat(m_flush, 64'd7)));
    check("tmo_a", {63'd0, to_a}, {63'd0, m_to_a});
    check("tmo_b", {63'd0, to_b}, {63'd0, m_to_b});
    if (r) begin
      m_wait = 1'b0; m_wcnt = 0; m_to_a = 1'b0; m_to_b = 1'b0;
      m_stall = 0; m_flush = 0;
    end else if (fz) begin
      m_wait = 1'b1; m_wcnt++; m_stall++;
      if (m_wcnt >= 16) m_to_a = 1'b1;
      if (m_wcnt >= 4)  m_to_b = 1'b1;
    end else begin
      m_wait = 1'b0; m_wcnt = 0;
      if (b)       m_flush++;
      else if (lu) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ready);
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, ready);
  endtask

  initial begin
    int pct;
    @(posedge clk);
    #1;
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // load-use on rs2, then default cycle
    cyc(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    // load to x0 never stalls
    cyc(1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // branch overrides load-use
    cyc(1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    // three-cycle memory wait then ready
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    // long wait trips the small-timeout instance, flag stays set
    for (int i = 0; i < 7; i++) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b0);
    // reset mid wait, no freeze afterwards without a new access
    for (int i = 0; i < 2; i++) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    // ten bubbles saturate the 3-bit counter
    for (int i = 0; i < 10; i++) cyc(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    // randomized traffic with phases of slow and fast memory
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 4;
          1:       pct = 50;
          default: pct = 90;
        endcase
      end
      cyc($urandom_range(0, 99) < 1,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < pct);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard sequencer for the 5-stage RISC-V core. It drives the PC and IF/ID write enables, the ID/EX bubble and the IF/ID and ID/EX flushes, plus a whole-pipeline freeze for variable-latency data memory. It covers every hazard the forwarding paths cannot resolve: load-use, taken branch/jump and data-memory wait. It also keeps a memory-timeout error flag and saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive freeze cycles that set mem_timeout; legal range 1..65535.
- CNT_W, 32: width of the performance counters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
- if_id_uses_rs1, if_id_uses_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
- id_ex_rd  in  5  destination register of the instruction in EX.
- id_ex_memread  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  a branch/jump resolved taken in EX this cycle.
- ex_mem_memaccess  in  1  a load/store is in MEM this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_bubble  out  1  load NOP control into ID/EX.
- if_id_flush, id_ex_flush  out  1 each  clear the stage register.
- pipe_freeze  out  1  hold PC and all four pipeline registers.
- mem_timeout  out  1  sticky error flag, registered.
- stall_cycles  out  CNT_W  count of load-use bubbles plus freeze cycles, registered.
- flush_count  out  CNT_W  count of branch flush events, registered.

## Operation
- State register with two states: RUN and MEM_WAIT. Control outputs are combinational from the state and the current inputs.
- Input conditions:
  - freeze_c = (state==MEM_WAIT && !dmem_ready) || (state==RUN && ex_mem_memaccess && !dmem_ready).
  - load_use = id_ex_memread && id_ex_rd!=0 && ((if_id_uses_rs1 && id_ex_rd==if_id_rs1) || (if_id_uses_rs2 && id_ex_rd==if_id_rs2)).
- Priority, highest first:
  1. rst: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_freeze=0.
  2. freeze_c: pipe_freeze=1, pc_write=0, if_id_write=0, and no bubble or flush. ex_branch_taken and load_use are ignored because they re-present after the freeze.
  3. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0. This overrides a simultaneous load_use.
  4. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1.
  5. Default: pc_write=1, if_id_write=1, all other outputs 0.
- Transitions:
  - RUN→MEM_WAIT when ex_mem_memaccess && !dmem_ready.
  - MEM_WAIT→RUN on the cycle dmem_ready=1. In that cycle pipe_freeze=0 and the pipeline advances.
  - A stray dmem_ready in RUN without ex_mem_memaccess has no effect.
- wait_cnt (16-bit, internal): counts consecutive freeze cycles.
  - Set to 1 on the RUN entry cycle.
  - +1 for each MEM_WAIT cycle with !dmem_ready, saturating at 65535.
  - Cleared to 0 on return to RUN.
- mem_timeout: set when the next value of wait_cnt equals MEM_TIMEOUT. It stays set until rst and does not alter freeze behaviour.
- stall_cycles: +1 for each cycle with pipe_freeze=1 or id_ex_bubble=1.
- flush_count: +1 for each cycle in which a branch flush is applied (priority 3).
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All control outputs have zero latency and apply in the same cycle as their cause.
- A load-use stall lasts exactly one cycle: the bubble clears the hazard and the next cycle is default unless a new hazard appears.
- A memory wait of N not-ready cycles produces N freeze cycles. The pipeline advances in the ready cycle.
- Registered outputs update on the clk edge following their cause.
- Reset values: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_count=0.
- rst asserted mid-MEM_WAIT: on the next edge the state returns to RUN and the counters clear. There is no freeze while rst is high.

## Test plan
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5, uses_rs2=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1 on the next cycle.
- Load to x0 with if_id_rs1=0, uses_rs1=1 -> no stall, all default outputs.
- Load-use and ex_branch_taken in the same cycle -> both flushes=1, pc_write=1, bubble=0; flush_count+1, stall_cycles unchanged.
- Memory access with dmem_ready low for 3 cycles, then high -> pipe_freeze=1 for 3 cycles, 0 in the ready cycle; state back to RUN; stall_cycles=3.
- MEM_TIMEOUT=4 with dmem_ready held low -> mem_timeout rises on cycle 5 of the freeze, stays set after ready arrives, and clears only on rst.
- rst pulsed during MEM_WAIT, and CNT_W=3 with 10 bubbles -> state returns to RUN and counters read 0 after reset; stall_cycles saturates at 7.
